// File: rtl/fetch_pkg.sv
// Shared constants and the fetch buffer entry type for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] PC_INCREMENT         = 32'd4;
    localparam logic [31:0] PC_READ_OFFSET       = 32'd8;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry_t;

    // Redirect targets are word addresses; low bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] address);
        return {address[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Flushable synchronous FIFO of fetch entries between the PC stage and decode.
// Latency: an entry pushed at edge N is visible at the head after edge N.
// Backpressure: caller must not push when full without a same-edge pop; flush beats push.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head_entry,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   storage [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push    = push && !flush;
    assign do_pop     = pop && (count != '0);
    assign head_entry = storage[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (do_push) begin
            storage[wr_ptr] <= push_entry;
        end
    end

    // A pop on the flush edge is still honoured by the consumer; the pointers
    // simply restart from an empty state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads combinational imem, buffers {pc, instr} toward decode.
// Latency: PC to decode 1 edge; redirect penalty 2 edges.
// Backpressure: decode_ready low fills the buffer, then the PC holds until a pop frees a slot.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          BUFFER_DEPTH = 2,
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic                            clock,
    input  logic                            reset_n,
    output logic [31:0]                     imem_address,
    input  logic [31:0]                     imem_read_data,
    input  logic                            redirect_valid,
    input  logic [31:0]                     redirect_target,
    output logic                            decode_valid,
    input  logic                            decode_ready,
    output logic [31:0]                     decode_instruction,
    output logic [31:0]                     decode_pc,
    output logic [31:0]                     decode_pc_plus_8,
    output logic [$clog2(BUFFER_DEPTH):0]   buffer_count
);

    localparam int CW = $clog2(BUFFER_DEPTH) + 1;

    logic [31:0]  pc;
    logic         push;
    logic         pop;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;
    logic [CW-1:0] count;
    logic         unused_target_bits;

    assign unused_target_bits = ^redirect_target[1:0];

    // decode_valid is purely state, so pop never loops back into itself.
    assign decode_valid = (count != '0);
    assign pop          = decode_valid && decode_ready;
    assign push         = !redirect_valid && ((count < CW'(BUFFER_DEPTH)) || pop);

    assign push_entry.pc          = pc;
    assign push_entry.instruction = imem_read_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_VECTOR;
        end else if (redirect_valid) begin
            pc <= word_align(redirect_target);
        end else if (push) begin
            pc <= pc + PC_INCREMENT;
        end
    end

    fetch_buffer #(
        .DEPTH (BUFFER_DEPTH)
    ) u_fetch_buffer (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_entry (head_entry),
        .count      (count)
    );

    assign imem_address       = pc;
    assign decode_instruction = head_entry.instruction;
    assign decode_pc          = head_entry.pc;
    assign decode_pc_plus_8   = head_entry.pc + PC_READ_OFFSET;
    assign buffer_count       = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, PC wrap, async reset.
module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic [31:0] imem_address;
    logic [31:0] imem_read_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        decode_valid;
    logic        decode_ready;
    logic [31:0] decode_instruction;
    logic [31:0] decode_pc;
    logic [31:0] decode_pc_plus_8;
    logic [1:0]  buffer_count;

    int tests_run;
    int tests_failed;

    localparam logic [31:0] PATTERN = 32'hA5A5_0000;

    fetch_unit #(
        .BUFFER_DEPTH (2),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .imem_address       (imem_address),
        .imem_read_data     (imem_read_data),
        .redirect_valid     (redirect_valid),
        .redirect_target    (redirect_target),
        .decode_valid       (decode_valid),
        .decode_ready       (decode_ready),
        .decode_instruction (decode_instruction),
        .decode_pc          (decode_pc),
        .decode_pc_plus_8   (decode_pc_plus_8),
        .buffer_count       (buffer_count)
    );

    assign imem_read_data = imem_address ^ PATTERN;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %08h, expected %08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, " valid"}, {31'd0, decode_valid}, 32'd1);
        check({tag, " pc"}, decode_pc, pc);
        check({tag, " instr"}, decode_instruction, pc ^ PATTERN);
        check({tag, " pc8"}, decode_pc_plus_8, pc + 32'd8);
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        reset_n         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        decode_ready    = 1'b1;

        // Reset state, observed before any edge is taken out of reset
        #12;
        check("rst valid", {31'd0, decode_valid}, 32'd0);
        check("rst count", {30'd0, buffer_count}, 32'd0);
        check("rst imem", imem_address, 32'h0);
        check("rst instr", decode_instruction, 32'h0);
        check("rst pc", decode_pc, 32'h0);
        check("rst pc8", decode_pc_plus_8, 32'h8);
        reset_n = 1'b1;

        // Streaming with ready held high: one instruction per cycle
        for (int k = 0; k < 6; k++) begin
            step();
            check_head($sformatf("stream%0d", k), 32'(k * 4));
            check($sformatf("stream%0d cnt", k), {30'd0, buffer_count}, 32'd1);
        end

        // Async reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        check("async valid", {31'd0, decode_valid}, 32'd0);
        check("async count", {30'd0, buffer_count}, 32'd0);
        check("async imem", imem_address, 32'h0);

        // Backpressure: ready low for 5 edges after reset release
        decode_ready = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("bp count", {30'd0, buffer_count}, 32'd2);
        check("bp imem", imem_address, 32'h8);
        check_head("bp head", 32'h0);
        decode_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step();
            check_head($sformatf("drain%0d", k), 32'(k * 4));
            check($sformatf("drain%0d cnt", k), {30'd0, buffer_count}, 32'd2);
        end

        // Redirect with two entries buffered, decode stalled
        decode_ready = 1'b0;
        step();
        check("pre-redir count", {30'd0, buffer_count}, 32'd2);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0043;
        step();
        redirect_valid = 1'b0;
        check("redir count", {30'd0, buffer_count}, 32'd0);
        check("redir valid", {31'd0, decode_valid}, 32'd0);
        check("redir imem", imem_address, 32'h40);
        step();
        check_head("redir first", 32'h40);
        check("redir first cnt", {30'd0, buffer_count}, 32'd1);

        // Full buffer: pop and redirect on the same edge
        step();
        check("full count", {30'd0, buffer_count}, 32'd2);
        decode_ready    = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        check("popflush count", {30'd0, buffer_count}, 32'd0);
        check("popflush valid", {31'd0, decode_valid}, 32'd0);
        check("popflush imem", imem_address, 32'h100);
        step();
        check_head("popflush first", 32'h100);
        step();
        check_head("popflush second", 32'h104);

        // PC wrap at the top of the address space
        decode_ready    = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap imem", imem_address, 32'hFFFF_FFFC);
        step();
        check("wrap pc", decode_pc, 32'hFFFF_FFFC);
        check("wrap pc8", decode_pc_plus_8, 32'h4);
        check("wrap instr", decode_instruction, 32'h5A5A_FFFC);
        check("wrap imem next", imem_address, 32'h0);
        step();
        check("wrap count", {30'd0, buffer_count}, 32'd2);
        decode_ready = 1'b1;
        step();
        check_head("wrap second", 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
